hvac_cycle_ctrl: RTL and testbench

Thermostat sequencer that drives the heating element and cooling unit of the room-conditioning datapath from the target and ambient temperatures. It sits between the operator controls (`A`/`B`) and the conditioning actuators, adds hysteresis plus minimum-on/minimum-off anti-short-cycle timing, and drives the red/green status lamps (`LR`/`LG`).

---
 rtl/hvac_cycle_ctrl_pkg.sv | 22 ++
 rtl/hvac_cycle_ctrl_if.sv | 27 ++
 rtl/hvac_cycle_ctrl_timer.sv | 25 ++
 rtl/hvac_cycle_ctrl.sv | 96 +++++++++
 tb/tb_hvac_cycle_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/hvac_cycle_ctrl_pkg.sv
// Shared definitions for the thermostat sequencer: state codes, state width,
// and the sizing rule for the shared run/rest timer.
package heat_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_OFF  = 3'd0,
        S_IDLE = 3'd1,
        S_HEAT = 3'd2,
        S_COOL = 3'd3,
        S_REST = 3'd4
    } state_t;

    // One extra bit so the larger of the two lengths always fits.
    function automatic int timer_w(input int min_on, input int min_off);
        int m;
        m = (min_on > min_off) ? min_on : min_off;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/hvac_cycle_ctrl_if.sv
// Operator controls, temperatures, actuator commands and status lamps of the
// thermostat sequencer, bundled as one port.
interface hvac_cycle_ctrl_if
    import heat_pkg::*;
#(
    parameter int TEMP_W = 8
);
    logic              A;
    logic              B;
    logic [TEMP_W-1:0] target;
    logic [TEMP_W-1:0] ambient;
    logic              heat_on;
    logic              cool_on;
    logic              LR;
    logic              LG;
    logic [STATE_W-1:0] state;

    modport master (
        output A, B, target, ambient,
        input  heat_on, cool_on, LR, LG, state
    );

    modport slave (
        input  A, B, target, ambient,
        output heat_on, cool_on, LR, LG, state
    );
endinterface

// File: rtl/hvac_cycle_ctrl_timer.sv
// Loadable down-counter that saturates at zero; done flags a zero count.
module heat_timer #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/hvac_cycle_ctrl.sv
// Thermostat sequencer: hysteresis plus min-on/min-off anti-short-cycle
// control of the heating element and cooling unit, with status lamps.
module hvac_cycle_ctrl
    import heat_pkg::*;
#(
    parameter int TEMP_W  = 8,
    parameter int HYST    = 2,
    parameter int MIN_ON  = 16,
    parameter int MIN_OFF = 16
) (
    input  logic              clock,
    input  logic              rst,
    hvac_cycle_ctrl_if.slave  bus
);
    localparam int              TW      = timer_w(MIN_ON, MIN_OFF);
    localparam logic [TW-1:0]   RUN_LD  = TW'(MIN_ON - 1);
    localparam logic [TW-1:0]   REST_LD = TW'(MIN_OFF - 1);
    localparam logic [TEMP_W:0] HYST_X  = (TEMP_W + 1)'(HYST);

    state_t          cur;
    state_t          nxt;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_done;
    logic [TEMP_W:0] amb_x;
    logic [TEMP_W:0] tgt_x;
    logic            too_cold;
    logic            too_hot;
    logic            heat_r;
    logic            cool_r;
    logic            lr_r;
    logic            lg_r;

    // Widened by one bit so adding the band can never wrap.
    assign amb_x    = {1'b0, bus.ambient};
    assign tgt_x    = {1'b0, bus.target};
    assign too_cold = (amb_x + HYST_X) < tgt_x;
    assign too_hot  = amb_x > (tgt_x + HYST_X);

    always_comb begin
        nxt = cur;
        case (cur)
            S_OFF:  if (bus.A) nxt = S_IDLE;
            S_IDLE: begin
                if (!bus.A)                nxt = S_OFF;
                else if (too_cold)         nxt = S_HEAT;
                else if (too_hot && bus.B) nxt = S_COOL;
            end
            S_HEAT: begin
                if (!bus.A)                                  nxt = S_REST;
                else if (tmr_done && bus.ambient >= bus.target) nxt = S_REST;
            end
            S_COOL: begin
                if (!bus.A) nxt = S_REST;
                else if (tmr_done && (bus.ambient <= bus.target || !bus.B)) nxt = S_REST;
            end
            S_REST: if (tmr_done) nxt = bus.A ? S_IDLE : S_OFF;
            default: nxt = S_OFF;
        endcase
    end

    // The timer restarts on every entry into a run or a rest.
    assign tmr_load = (nxt != cur) && (nxt == S_HEAT || nxt == S_COOL || nxt == S_REST);
    assign tmr_val  = (nxt == S_REST) ? REST_LD : RUN_LD;

    heat_timer #(.W(TW)) u_timer (
        .clock    (clock),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            cur    <= S_OFF;
            heat_r <= 1'b0;
            cool_r <= 1'b0;
            lr_r   <= 1'b0;
            lg_r   <= 1'b0;
        end else begin
            cur    <= nxt;
            heat_r <= (nxt == S_HEAT);
            cool_r <= (nxt == S_COOL);
            lr_r   <= (nxt == S_HEAT) || (nxt == S_COOL) || (nxt == S_REST);
            lg_r   <= (nxt == S_IDLE) || (nxt == S_REST);
        end
    end

    assign bus.heat_on = heat_r;
    assign bus.cool_on = cool_r;
    assign bus.LR      = lr_r;
    assign bus.LG      = lg_r;
    assign bus.state   = cur;

endmodule

// File: tb/tb_hvac_cycle_ctrl.sv
// Directed scenario bench for hvac_cycle_ctrl with TEMP_W=8, HYST=2,
// MIN_ON=4, MIN_OFF=3.
module tb_hvac_cycle_ctrl;

    // {heat_on, cool_on, LR, LG, state}
    localparam logic [6:0] P_OFF  = 7'b0000_000;
    localparam logic [6:0] P_IDLE = 7'b0001_001;
    localparam logic [6:0] P_HEAT = 7'b1010_010;
    localparam logic [6:0] P_COOL = 7'b0110_011;
    localparam logic [6:0] P_REST = 7'b0011_100;

    logic clock;
    logic rst;
    int   total;
    int   passed;
    logic [6:0] obs;

    hvac_cycle_ctrl_if #(.TEMP_W(8)) bus ();

    hvac_cycle_ctrl #(
        .TEMP_W  (8),
        .HYST    (2),
        .MIN_ON  (4),
        .MIN_OFF (3)
    ) dut (
        .clock (clock),
        .rst   (rst),
        .bus   (bus)
    );

    assign obs = {bus.heat_on, bus.cool_on, bus.LR, bus.LG, bus.state};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.A = 1'b1;
        bus.B = 1'b0;
        bus.target = 8'd20;
        bus.ambient = 8'd20;
        #2 rst = 1'b0;
        #1;
        total++;
        if (obs !== P_OFF) $display("FAIL reset_async: got %b want %b", obs, P_OFF);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== P_OFF) $display("FAIL reset_hold%0d: got %b want %b", i, obs, P_OFF);
            else passed++;
        end
        rst = 1'b1;
        tick();
        total++;
        if (obs !== P_IDLE) $display("FAIL reset_to_idle: got %b want %b", obs, P_IDLE);
        else passed++;
    endtask

    task automatic test_heat_cycle();
        bus.ambient = 8'd17;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) bus.ambient = 8'd20;
            total++;
            if (obs !== P_HEAT) $display("FAIL heat_run%0d: got %b want %b", i, obs, P_HEAT);
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== P_REST) $display("FAIL heat_rest%0d: got %b want %b", i, obs, P_REST);
            else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== P_IDLE) $display("FAIL heat_idle%0d: got %b want %b", i, obs, P_IDLE);
            else passed++;
        end
    endtask

    task automatic test_hysteresis();
        bus.B = 1'b1;
        bus.target = 8'd20;
        bus.ambient = 8'd18;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== P_IDLE) $display("FAIL hyst_low%0d: got %b want %b", i, obs, P_IDLE);
            else passed++;
        end
        bus.ambient = 8'd22;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== P_IDLE) $display("FAIL hyst_high%0d: got %b want %b", i, obs, P_IDLE);
            else passed++;
        end
        bus.ambient = 8'd23;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 0) bus.ambient = 8'd20;
            total++;
            if (obs !== P_COOL) $display("FAIL hyst_cool%0d: got %b want %b", i, obs, P_COOL);
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== P_REST) $display("FAIL hyst_rest%0d: got %b want %b", i, obs, P_REST);
            else passed++;
        end
        tick();
        total++;
        if (obs !== P_IDLE) $display("FAIL hyst_idle: got %b want %b", obs, P_IDLE);
        else passed++;
    endtask

    task automatic test_cool_permit();
        bus.B = 1'b0;
        bus.target = 8'd20;
        bus.ambient = 8'd25;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== P_IDLE) $display("FAIL permit_block%0d: got %b want %b", i, obs, P_IDLE);
            else passed++;
        end
        bus.B = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (obs !== P_COOL) $display("FAIL permit_cool%0d: got %b want %b", i, obs, P_COOL);
            else passed++;
        end
        bus.B = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== P_REST) $display("FAIL permit_rest%0d: got %b want %b", i, obs, P_REST);
            else passed++;
        end
        tick();
        total++;
        if (obs !== P_IDLE) $display("FAIL permit_idle: got %b want %b", obs, P_IDLE);
        else passed++;
        bus.ambient = 8'd20;
    endtask

    task automatic test_abort();
        bus.ambient = 8'd17;
        tick();
        tick();
        total++;
        if (obs !== P_HEAT) $display("FAIL abort_run: got %b want %b", obs, P_HEAT);
        else passed++;
        bus.A = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs !== P_REST) $display("FAIL abort_rest%0d: got %b want %b", i, obs, P_REST);
            else passed++;
        end
        bus.ambient = 8'd20;
        tick();
        total++;
        if (obs !== P_OFF) $display("FAIL abort_off: got %b want %b", obs, P_OFF);
        else passed++;
    endtask

    task automatic test_reset_midrun();
        bus.A = 1'b1;
        tick();
        total++;
        if (obs !== P_IDLE) $display("FAIL midrst_idle: got %b want %b", obs, P_IDLE);
        else passed++;
        bus.ambient = 8'd17;
        tick();
        tick();
        total++;
        if (obs !== P_HEAT) $display("FAIL midrst_run: got %b want %b", obs, P_HEAT);
        else passed++;
        #2 rst = 1'b0;
        #1;
        total++;
        if (bus.heat_on !== 1'b0) $display("FAIL midrst_heat_drop: got %b want 0", bus.heat_on);
        else passed++;
        total++;
        if (obs !== P_OFF) $display("FAIL midrst_off: got %b want %b", obs, P_OFF);
        else passed++;
        #1 rst = 1'b1;
        bus.ambient = 8'd20;
        tick();
        total++;
        if (obs !== P_IDLE) $display("FAIL midrst_no_rest: got %b want %b", obs, P_IDLE);
        else passed++;
    endtask

    task automatic test_overflow();
        bus.B = 1'b1;
        bus.target = 8'd255;
        bus.ambient = 8'd254;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== P_IDLE) $display("FAIL ovf_top%0d: got %b want %b", i, obs, P_IDLE);
            else passed++;
        end
        bus.target = 8'd1;
        bus.ambient = 8'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs !== P_IDLE) $display("FAIL ovf_bottom%0d: got %b want %b", i, obs, P_IDLE);
            else passed++;
        end
        bus.target = 8'd3;
        tick();
        total++;
        if (obs !== P_HEAT) $display("FAIL ovf_edge_heat: got %b want %b", obs, P_HEAT);
        else passed++;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        test_reset();
        test_heat_cycle();
        test_hysteresis();
        test_cool_permit();
        test_abort();
        test_reset_midrun();
        test_overflow();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
